// File: rtl/render_pkg.sv
// Shared render-pipeline types: requester ids, default SRAM geometry and the
// read-tag record that travels alongside each in-flight SRAM read.
package render_pkg;

    localparam int NUM_REQ    = 3;
    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 32;
    localparam int ID_W       = $clog2(NUM_REQ);

    localparam logic [ID_W-1:0] REQ_FACE = ID_W'(0);
    localparam logic [ID_W-1:0] REQ_VERT = ID_W'(1);
    localparam logic [ID_W-1:0] REQ_ZBUF = ID_W'(2);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/sram_port_arbiter_rr_arb.sv
// Combinational one-hot grant with a rotating start pointer.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module rr_arb
    import render_pkg::*;
#(
    parameter int N_REQ = NUM_REQ
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt
);

`ifdef ARB_FIXED_PRIO_EN
    // Walk from the top down so the lowest requesting index is the final writer.
    always_comb begin
        gnt = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i] && srst_n) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end
`else
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] rr_ptr_d;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    // Walk the search order backwards so the candidate nearest rr_ptr wins.
    always_comb begin
        gnt      = '0;
        rr_ptr_d = rr_ptr_q;
        sum      = '0;
        idx      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(N_REQ)) begin
                sum = sum - (PTR_W + 1)'(N_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (req[idx] && srst_n) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                rr_ptr_d = (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between face fetch, vertex fetch and z-buffer; reads are
// tagged through the fixed SRAM latency and returned to their issuer in order.
module sram_port_arbiter
    import render_pkg::*;
#(
    parameter int N_REQ  = NUM_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 3
) (
    input  logic                      clk,
    input  logic                      srst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      sram_cs,
    output logic                      sram_we,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic [DATA_W-1:0]         sram_wdata,
    input  logic [DATA_W-1:0]         sram_rdata
);

    logic [N_REQ-1:0]  gnt;
    logic              any_gnt;
    logic              sel_we;
    logic [ID_W-1:0]   sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              sram_cs_q,    sram_cs_d;
    logic              sram_we_q,    sram_we_d;
    logic [ADDR_W-1:0] sram_addr_q,  sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
    logic [N_REQ-1:0]  rsp_valid_q,  rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,   rsp_data_d;
    rd_tag_t           tag_q [RD_LAT+1];
    rd_tag_t           tag_d [RD_LAT+1];

    rr_arb #(.N_REQ(N_REQ)) u_rr_arb (
        .clk    (clk),
        .srst_n (srst_n),
        .req    (req_valid),
        .gnt    (gnt)
    );

    assign req_ready = gnt;
    assign any_gnt   = |gnt;

    always_comb begin
        sel_we    = 1'b0;
        sel_id    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_we    = req_we[i];
                sel_id    = ID_W'(i);
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Tag stage RD_LAT lines up with the cycle sram_rdata is valid for that read.
    always_comb begin
        sram_cs_d    = any_gnt;
        sram_we_d    = any_gnt & sel_we;
        sram_addr_d  = any_gnt ? sel_addr  : sram_addr_q;
        sram_wdata_d = any_gnt ? sel_wdata : sram_wdata_q;
        tag_d[0]     = '{vld: any_gnt & ~sel_we, id: sel_id};
        for (int s = 1; s <= RD_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tag_q[RD_LAT].vld) begin
            rsp_valid_d[tag_q[RD_LAT].id] = 1'b1;
            rsp_data_d                    = sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            sram_cs_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            for (int s = 0; s <= RD_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            sram_cs_q    <= sram_cs_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            for (int s = 0; s <= RD_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    assign sram_cs    = sram_cs_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;

endmodule
